// File: rtl/vga_pkg.sv
// vga_pkg: console FSM states, control-code bytes and the printable-byte test
package vga_pkg;

    typedef enum logic [1:0] {IDLE, PUT, FILL_LINE, FILL_ALL} state_t;

    localparam logic [7:0] CH_BS = 8'h08;
    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_FF = 8'h0C;
    localparam logic [7:0] CH_CR = 8'h0D;
    localparam logic [7:0] CH_SP = 8'h20;

    function automatic logic is_print(input logic [7:0] c);
        return c >= 8'h20 && c <= 8'h7E;
    endfunction

endpackage

// File: rtl/vga_console_fill.sv
// vga_console_fill: space-fill address generator for one text row or the whole screen
module vga_console_fill #(
    parameter int cols       = 210,
    parameter int rows       = 131,
    parameter int addr_width = $clog2(cols*rows)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_start,
    input  logic                    i_line,
    input  logic [$clog2(rows)-1:0] i_row,
    output logic [addr_width-1:0]   o_addr,
    output logic                    o_last
);
    // one extra bit so a full-screen count of exactly 2**addr_width still fits
    localparam int CW = addr_width + 1;

    logic [addr_width-1:0] r_addr;
    logic [CW-1:0]         r_left;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr <= '0;
            r_left <= '0;
        end else if (i_start) begin
            r_addr <= i_line ? addr_width'(i_row) * addr_width'(cols) : '0;
            r_left <= i_line ? CW'(cols) : CW'(cols*rows);
        end else if (r_left != '0) begin
            r_addr <= r_addr + addr_width'(1);
            r_left <= r_left - CW'(1);
        end
    end

    assign o_addr = r_addr;
    assign o_last = r_left == CW'(1);

endmodule

// File: rtl/vga_console.sv
// vga_console: byte stream to text-buffer writer; VGA_CONSOLE_CLEAR_ON_RESET_EN clears the screen after reset
module vga_console
    import vga_pkg::*;
#(
    parameter int cols       = 210,
    parameter int rows       = 131,
    parameter int addr_width = $clog2(cols*rows)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    char_valid,
    input  logic [7:0]              char_data,
    output logic                    char_ready,
    output logic [addr_width-1:0]   wr_addr,
    output logic [7:0]              wr_data,
    output logic                    wr_en,
    output logic [$clog2(cols)-1:0] cursor_x,
    output logic [$clog2(rows)-1:0] cursor_y,
    output logic                    busy
);
    localparam int XW = $clog2(cols);
    localparam int YW = $clog2(rows);

    state_t                r_state, w_next;
    logic                  w_acc, w_we, w_start, w_line, w_fill_last, w_x_last;
    logic [7:0]            w_wd;
    logic [addr_width-1:0] w_wa, w_cur, w_fill_addr;
    logic [XW-1:0]         w_x;
    logic [YW-1:0]         w_y, w_y_inc;
`ifdef VGA_CONSOLE_CLEAR_ON_RESET_EN
    logic                  r_boot;
`endif

    assign w_acc    = char_valid & char_ready;
    assign w_cur    = addr_width'(cursor_y) * addr_width'(cols) + addr_width'(cursor_x);
    assign w_x_last = cursor_x == XW'(cols-1);
    assign w_y_inc  = (cursor_y == YW'(rows-1)) ? '0 : cursor_y + YW'(1);
    assign busy     = (r_state == FILL_LINE) || (r_state == FILL_ALL);

    always_comb begin
        w_next  = r_state;
        w_x     = cursor_x;
        w_y     = cursor_y;
        w_we    = 1'b0;
        w_wd    = CH_SP;
        w_wa    = w_fill_addr;
        w_start = 1'b0;
        w_line  = 1'b0;
        case (r_state)
            IDLE: if (w_acc) begin
                w_next = PUT;
                if (is_print(char_data)) begin
                    w_we = 1'b1;
                    w_wd = char_data;
                    w_wa = w_cur;
                    w_x  = cursor_x + XW'(1);
                end
                // line wrap and LF both land on a fresh row that must be blanked
                if ((is_print(char_data) && w_x_last) || char_data == CH_LF) begin
                    w_x     = '0;
                    w_y     = w_y_inc;
                    w_next  = FILL_LINE;
                    w_start = 1'b1;
                    w_line  = 1'b1;
                end
                if (char_data == CH_CR)
                    w_x = '0;
                if (char_data == CH_BS && cursor_x != '0) begin
                    w_x  = cursor_x - XW'(1);
                    w_we = 1'b1;
                    w_wa = w_cur - addr_width'(1);
                end
                if (char_data == CH_FF) begin
                    w_x     = '0;
                    w_y     = '0;
                    w_next  = FILL_ALL;
                    w_start = 1'b1;
                end
            end
`ifdef VGA_CONSOLE_CLEAR_ON_RESET_EN
            else if (r_boot) begin
                w_next  = FILL_ALL;
                w_start = 1'b1;
            end
`endif
            PUT: w_next = IDLE;
            FILL_LINE, FILL_ALL: begin
                w_we   = 1'b1;
                w_next = w_fill_last ? IDLE : r_state;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            cursor_x   <= '0;
            cursor_y   <= '0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            char_ready <= 1'b0;
        end else begin
            r_state    <= w_next;
            cursor_x   <= w_x;
            cursor_y   <= w_y;
            wr_en      <= w_we;
            char_ready <= w_next == IDLE;
            if (w_we) begin
                wr_addr <= w_wa;
                wr_data <= w_wd;
            end
        end
    end

`ifdef VGA_CONSOLE_CLEAR_ON_RESET_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_boot <= 1'b1;
        else
            r_boot <= 1'b0;
    end
`endif

    vga_console_fill #(
        .cols       (cols),
        .rows       (rows),
        .addr_width (addr_width)
    ) u_fill (
        .clk     (clk),
        .reset   (reset),
        .i_start (w_start),
        .i_line  (w_line),
        .i_row   (w_y),
        .o_addr  (w_fill_addr),
        .o_last  (w_fill_last)
    );

endmodule
